// File: rtl/uart_regs_pkg.sv
// Shared register-map offsets, STATUS bit positions, FSM states and RX buffer depth
// for the UART register peripheral.
package uart_regs_pkg;

  localparam logic [6:0] OFF_TX_DATA = 7'd0;
  localparam logic [6:0] OFF_STATUS  = 7'd1;
  localparam logic [6:0] OFF_RX_DATA = 7'd2;

  localparam int STATUS_TX_READY     = 0;
  localparam int STATUS_RX_VALID     = 1;
  localparam int STATUS_RX_OVERRUN   = 2;
  localparam int STATUS_RX_FRAME_ERR = 3;

  localparam int RX_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_receiver.sv
// 8N1 receiver: 2-flop synchronizer on uart_rx and a start/data/stop sampling FSM.
// Emits a single-cycle rx_strobe (good stop bit) or frame_err_pulse (bad stop bit).
module uart_receiver
  import uart_regs_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       rx_strobe,
  output logic [7:0] rx_byte,
  output logic       frame_err_pulse
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLOCKS_PER_BIT / 2);

  logic [1:0]    sync_reg;
  logic          rx_line;
  uart_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          bit_end;
  logic          bit_half;

  // Synchronizer idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], uart_rx};
    end
  end

  assign rx_line  = sync_reg[1];
  assign bit_end  = (cnt_reg == BIT_LAST);
  assign bit_half = (cnt_reg == BIT_HALF);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (!rx_line) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        cnt_next = cnt_reg + 1'b1;
        if (bit_half) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rx_line ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
        if (bit_end) begin
          shift_next = {rx_line, shift_reg[7:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == 3'd7) begin
            state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
        if (bit_end) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  assign rx_strobe       = (state_reg == ST_STOP) && bit_end && rx_line;
  assign frame_err_pulse = (state_reg == ST_STOP) && bit_end && !rx_line;
  assign rx_byte         = shift_reg;

endmodule

// File: rtl/uart_register_peripheral.sv
// Memory-mapped 8N1 UART: register decode, TX FSM and RX buffer.
// Define UART_RX_FIFO_EN for a 4-entry RX FIFO; otherwise a single holding register.
module uart_register_peripheral
  import uart_regs_pkg::*;
#(
  parameter int         CLOCKS_PER_BIT = 16,
  parameter logic [6:0] BASE_INDEX     = 7'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLOCKS_PER_BIT - 1);

  logic [6:0] offset;
  logic       sel_tx, sel_status, sel_rx;
  logic       unused_write_bits;

  assign offset            = register_index - BASE_INDEX;
  assign sel_tx            = (offset == OFF_TX_DATA);
  assign sel_status        = (offset == OFF_STATUS);
  assign sel_rx            = (offset == OFF_RX_DATA);
  assign unused_write_bits = ^register_write_value[15:8];

  // ---------------- TX ----------------
  uart_state_t   tx_state_reg, tx_state_next;
  logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]    tx_bit_reg, tx_bit_next;
  logic [7:0]    tx_shift_reg, tx_shift_next;
  logic          tx_line_reg, tx_line_next;
  logic          tx_start;
  logic          tx_bit_end;

  assign tx_start   = register_write && sel_tx && (tx_state_reg == ST_IDLE);
  assign tx_bit_end = (tx_cnt_reg == BIT_LAST);

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    if (tx_state_reg != ST_IDLE) begin
      tx_cnt_next = tx_bit_end ? '0 : tx_cnt_reg + 1'b1;
    end
    case (tx_state_reg)
      ST_IDLE: begin
        if (tx_start) begin
          tx_state_next = ST_START;
          tx_cnt_next   = '0;
          tx_shift_next = register_write_value[7:0];
        end
      end
      ST_START: begin
        if (tx_bit_end) begin
          tx_state_next = ST_DATA;
          tx_bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (tx_bit_end) begin
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          tx_bit_next   = tx_bit_reg + 1'b1;
          if (tx_bit_reg == 3'd7) begin
            tx_state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tx_bit_end) begin
          tx_state_next = ST_IDLE;
        end
      end
      default: tx_state_next = ST_IDLE;
    endcase
    // Line level is registered from the next state so uart_tx is glitch-free.
    case (tx_state_next)
      ST_START: tx_line_next = 1'b0;
      ST_DATA:  tx_line_next = tx_shift_next[0];
      default:  tx_line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_reg <= ST_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_line_reg  <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_line_reg  <= tx_line_next;
    end
  end

  assign uart_tx = tx_line_reg;

  // ---------------- RX ----------------
  logic       rx_strobe;
  logic       frame_err_pulse;
  logic [7:0] rx_byte;

  uart_receiver #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_receiver (
    .clk            (clk),
    .reset          (reset),
    .uart_rx        (uart_rx),
    .rx_strobe      (rx_strobe),
    .rx_byte        (rx_byte),
    .frame_err_pulse(frame_err_pulse)
  );

  logic       pop, full, push_ok, overrun_set;
  logic       rx_valid_now, rx_valid_next;
  logic [7:0] rx_head;

  // A pop frees a slot for a push arriving in the same cycle.
  assign pop         = register_write && sel_rx && rx_valid_now;
  assign push_ok     = rx_strobe && (!full || pop);
  assign overrun_set = rx_strobe && full && !pop;

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_mem [RX_FIFO_DEPTH];
  logic [1:0] rd_ptr_reg, wr_ptr_reg;
  logic [2:0] count_reg, count_next;

  assign full         = (count_reg == 3'(RX_FIFO_DEPTH));
  assign rx_valid_now = (count_reg != 3'd0);
  assign rx_head      = fifo_mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop) begin
      count_next = count_reg + 3'd1;
    end else if (pop && !push_ok) begin
      count_next = count_reg - 3'd1;
    end
  end

  assign rx_valid_next = (count_next != 3'd0);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 2'd1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 2'd1;
      end
      count_reg <= count_next;
    end
  end
`else
  logic [7:0] hold_reg;
  logic       hold_valid_reg;

  assign full          = hold_valid_reg;
  assign rx_valid_now  = hold_valid_reg;
  assign rx_head       = hold_reg;
  assign rx_valid_next = push_ok || (hold_valid_reg && !pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
    end else begin
      hold_valid_reg <= rx_valid_next;
      if (push_ok) begin
        hold_reg <= rx_byte;
      end
    end
  end
`endif

  // ---------------- flags and read path ----------------
  logic        status_write;
  logic        overrun_reg, overrun_next;
  logic        frame_err_reg, frame_err_next;
  logic [15:0] status_next;
  logic [15:0] read_mux;
  logic [15:0] read_value_reg;

  assign status_write   = register_write && sel_status;
  // Set has priority over a write-1-to-clear in the same cycle.
  assign overrun_next   = overrun_set ||
                          (overrun_reg && !(status_write && register_write_value[STATUS_RX_OVERRUN]));
  assign frame_err_next = frame_err_pulse ||
                          (frame_err_reg && !(status_write && register_write_value[STATUS_RX_FRAME_ERR]));

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      overrun_reg   <= overrun_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // STATUS reports the state as it will be after this cycle's edge.
  always_comb begin
    status_next                      = '0;
    status_next[STATUS_TX_READY]     = (tx_state_next == ST_IDLE);
    status_next[STATUS_RX_VALID]     = rx_valid_next;
    status_next[STATUS_RX_OVERRUN]   = overrun_next;
    status_next[STATUS_RX_FRAME_ERR] = frame_err_next;
  end

  always_comb begin
    read_mux = '0;
    if (sel_status) begin
      read_mux = status_next;
    end else if (sel_rx && rx_valid_now) begin
      read_mux = {8'h00, rx_head};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_value_reg <= '0;
    end else if (register_read) begin
      read_value_reg <= read_mux;
    end
  end

  assign register_read_value = read_value_reg;

endmodule

// File: doc/uart_register_peripheral.md
# uart_register_peripheral

Memory-mapped 8N1 UART on the hardware-register bus of the ulisp top level. It decodes `register_index` and `register_read`/`register_write`, and returns read data registered one cycle after the access. This matches the core's read mux, which selects `register_read_value` in the cycle after a register access. It serializes transmit bytes onto `uart_tx` and deserializes `uart_rx` into a small receive buffer.

## Interface
- `CLOCKS_PER_BIT`, default 16: `clk` cycles per serial bit; must be ≥ 4.
- `BASE_INDEX`, default 7'd0: register index of the first of three consecutive registers.
- `clk` input, 1 bit: the single clock; all logic is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `register_index` input, 7 bits: register address from the core.
- `register_read` input, 1 bit: read access this cycle.
- `register_write` input, 1 bit: write access this cycle.
- `register_write_value` input, 16 bits: write data.
- `register_read_value` output, 16 bits: registered read data.
- `uart_tx` output, 1 bit: serial transmit line; idle high.
- `uart_rx` input, 1 bit: serial receive line; asynchronous.

## Operation
- Register map, offsets from `BASE_INDEX`:
  - +0 TX_DATA: a write of bits [7:0] starts a frame if `tx_ready`=1; a write while busy is dropped. Reads return 0.
  - +1 STATUS: read-only fields, with write-1-to-clear on the sticky flags.
    - bit0 `tx_ready`
    - bit1 `rx_valid`: buffer non-empty
    - bit2 `rx_overrun`: sticky
    - bit3 `rx_frame_err`: sticky
    - bits [15:4] read as 0
  - +2 RX_DATA: reads return the head byte in [7:0] and zeros above; 0 when empty. Reads have no side effect. Any write pops the head; a pop when empty has no effect.
- Unmapped indices: writes are ignored and reads return 0.
- TX state machine:
  - States: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE.
  - Each state or bit lasts `CLOCKS_PER_BIT` cycles.
- RX state machine:
  - `uart_rx` passes through a 2-flop synchronizer.
  - IDLE: a low level on the synchronized line moves to START.
  - START: samples at `CLOCKS_PER_BIT/2`. High returns to IDLE as a false start; low moves to DATA.
  - DATA: samples 8 bits at bit centres, LSB first, then moves to STOP.
  - STOP: samples at the bit centre.
    - Stop=1 pushes the byte.
    - Stop=0 discards the byte and sets `rx_frame_err`.
    - Both cases then return to IDLE.
- Push when the buffer is full: the byte is dropped and `rx_overrun` is set.
- Pop and push in the same cycle while full: the pop is applied first, the push is accepted, and `rx_overrun` is not set.
- Reset values:
  - `uart_tx`=1, `register_read_value`=0, both FSMs IDLE.
  - Buffer empty, all flags 0, `tx_ready`=1.

## Timing
- Read latency is 1 cycle: `register_read` in cycle N gives `register_read_value` valid in cycle N+1. It holds until the next read, and returns to 0 after reset.
- STATUS read in cycle N reflects state at the end of cycle N, including a push or pop in that cycle.
- TX write in cycle N:
  - `tx_ready`=0 from cycle N+1.
  - `uart_tx` goes low from cycle N+1.
  - Frame is exactly `10*CLOCKS_PER_BIT` cycles.
  - `tx_ready`=1 in the first cycle after the stop bit; a back-to-back write is accepted in that cycle.
- RX push occurs in the stop-bit centre cycle. `rx_valid` is visible in the next cycle.
- Sticky-flag clear and set in the same cycle: set wins.
- Reset mid-frame:
  - TX aborts and `uart_tx` returns high the next cycle.
  - RX discards the partial byte.
- Bit counters are `$clog2(CLOCKS_PER_BIT)` bits wide and wrap only on reload.

## Configuration
- `UART_RX_FIFO_EN` defined: the RX buffer is a 4-entry circular FIFO with 2-bit read/write pointers and a 3-bit count. Full means count=4.
- Undefined: the RX buffer is a single holding register. Full means `rx_valid`=1.
- The register map and all flag semantics are identical in both builds.

## Structure
- Shared package `uart_regs_pkg`:
  - Register offsets TX_DATA/STATUS/RX_DATA.
  - STATUS bit positions.
  - FSM state enum.
  - FIFO depth constant 4.
- Sub-module `uart_receiver`: synchronizer plus RX FSM, outputting a 1-cycle `rx_strobe`, `rx_byte[7:0]` and `frame_err_pulse`.
- The top level holds the register decode, TX FSM and RX buffer.

## Test plan
All scenarios use `CLOCKS_PER_BIT`=16 and `BASE_INDEX`=0.
- Write 0x00A5 to index 0 → `uart_tx` carries the pattern 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles. STATUS bit0=0 for 160 cycles, then 1.
- Drive frame 0x3C on `uart_rx`, then read index 2 → 0x003C. STATUS reads 0x0002. Write index 2, then STATUS reads 0x0000.
- Drive a 40-cycle-early... rather, drive a 4-cycle low glitch on `uart_rx` → no push, and STATUS remains 0x0000.
- Drive a frame with stop bit 0 → STATUS bit3=1 and no byte is pushed. Write 0x0008 to index 1 → bit3 clears.
- Drive 5 frames (FIFO build) or 2 frames (no-FIFO build) without popping → STATUS reads 0x0006. RX_DATA returns the first byte.
- Assert `reset` mid-TX at cycle 50 → `uart_tx`=1 and `register_read_value`=0 next cycle. A subsequent write to index 0 is accepted.
